// File: rtl/mem_access_ctrl.sv
// Memory access controller: MAR/MDR front end for a 512x32 ram with a setup
// cycle, WAIT_CYCLES strobe cycles and a req/ready/done handshake.
module mem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [31:0]       ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]      mdr_q, mdr_d;
    logic                   we_q, we_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   out_of_range;

    assign out_of_range = |addr_in[31:ADDR_BITS];

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    mar_d = addr_in[ADDR_BITS-1:0];
                    we_d  = we;
                    // A rejected write must leave MDR untouched.
                    if (out_of_range) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_SETUP;
                        if (we) begin
                            mdr_d = wdata;
                        end
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        mdr_d = ram_dout;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is decoded from registered state only.
    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign err       = (state_q == S_ERR);
    assign ram_read  = (state_q == S_ACCESS) && !we_q;
    assign ram_write = (state_q == S_ACCESS) && we_q;
    assign ram_addr  = {{(32-ADDR_BITS){1'b0}}, mar_q};
    assign ram_din   = mdr_q;
    assign rdata     = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 3) with ram models,
// table-driven accesses, a done-driven scoreboard and hand-written corner cases.
module tb_mem_access_ctrl;

    logic        clk;
    logic        clr;
    logic        req       [2];
    logic        we        [2];
    logic [31:0] addr_in   [2];
    logic [31:0] wdata     [2];
    logic        ready     [2];
    logic        done      [2];
    logic        err       [2];
    logic [31:0] rdata     [2];
    logic [31:0] ram_addr  [2];
    logic [31:0] ram_din   [2];
    logic        ram_read  [2];
    logic        ram_write [2];
    logic [31:0] ram_dout  [2];

    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];

    int cyc;
    int total_cnt;
    int pass_cnt;
    int wcyc [2];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          e0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          rd_cnt  [2];
    int          wr_cnt  [2];
    logic        bad     [2];
    logic        had_stb [2];
    logic [31:0] addr_hold [2];

    mem_access_ctrl #(.DATA_W(32), .ADDR_BITS(9), .WAIT_CYCLES(1)) dut (
        .clk(clk), .clr(clr), .req(req[0]), .we(we[0]), .addr_in(addr_in[0]),
        .wdata(wdata[0]), .ready(ready[0]), .done(done[0]), .err(err[0]),
        .rdata(rdata[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]),
        .ram_read(ram_read[0]), .ram_write(ram_write[0]), .ram_dout(ram_dout[0])
    );

    mem_access_ctrl #(.DATA_W(32), .ADDR_BITS(9), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .clr(clr), .req(req[1]), .we(we[1]), .addr_in(addr_in[1]),
        .wdata(wdata[1]), .ready(ready[1]), .done(done[1]), .err(err[1]),
        .rdata(rdata[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]),
        .ram_read(ram_read[1]), .ram_write(ram_write[1]), .ram_dout(ram_dout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ram models: combinational read, write on the strobe, 0x47 preloaded on reset.
    assign ram_dout[0] = mem0[ram_addr[0][8:0]];
    assign ram_dout[1] = mem1[ram_addr[1][8:0]];
    always @(posedge clk) begin
        if (clr) begin
            mem0[9'h047] <= 32'h94;
            mem1[9'h047] <= 32'h94;
        end else begin
            if (ram_write[0]) mem0[ram_addr[0][8:0]] <= ram_din[0];
            if (ram_write[1]) mem1[ram_addr[1][8:0]] <= ram_din[1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic mon_unit(input int u);
        exp_t e;
        int   lat;
        if (ram_read[u] && ram_write[u]) bad[u] = 1'b1;
        if (ram_read[u] || ram_write[u]) begin
            if (had_stb[u] && ram_addr[u] != addr_hold[u]) bad[u] = 1'b1;
            addr_hold[u] = ram_addr[u];
            had_stb[u]   = 1'b1;
            if (ram_read[u])  rd_cnt[u]++;
            if (ram_write[u]) wr_cnt[u]++;
        end
        if (done[u]) begin
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                total_cnt++;
                $display("FAIL unexpected_done[%0d]: got done=1, expected no done", u);
            end else begin
                if (u == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                lat = e.exp_err ? 0 : 1 + wcyc[u];
                chk($sformatf("err[%0d]", u), {31'd0, err[u]}, {31'd0, e.exp_err});
                chk($sformatf("rdata[%0d]", u), rdata[u], e.exp_rdata);
                chk($sformatf("latency[%0d]", u), cyc - e.e0, lat);
                chk($sformatf("rd_strobes[%0d]", u), rd_cnt[u],
                    (e.exp_err || e.we) ? 0 : wcyc[u]);
                chk($sformatf("wr_strobes[%0d]", u), wr_cnt[u],
                    (e.exp_err || !e.we) ? 0 : wcyc[u]);
                chk($sformatf("strobe_rules[%0d]", u), {31'd0, bad[u]}, 32'd0);
            end
        end
        if (ready[u]) begin
            rd_cnt[u]  = 0;
            wr_cnt[u]  = 0;
            bad[u]     = 1'b0;
            had_stb[u] = 1'b0;
        end
    endtask

    task automatic start_acc(input int u, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic ee, input logic [31:0] er);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!ready[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready[u]) begin
            total_cnt++;
            $display("FAIL ready_timeout[%0d]: got ready=0, expected ready=1", u);
        end
        req[u]     = 1'b1;
        we[u]      = w;
        addr_in[u] = a;
        wdata[u]   = d;
        e.we = w; e.exp_err = ee; e.exp_rdata = er; e.e0 = cyc + 1;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req[u]     = 1'b0;
        we[u]      = 1'b0;
        addr_in[u] = 32'h0;
        wdata[u]   = 32'h0;
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (((u == 0) ? q0.size() : q1.size()) != 0) begin
            total_cnt++;
            $display("FAIL done_timeout[%0d]: got no done, expected done", u);
        end
        repeat (3) @(negedge clk);
    endtask

    vec_t vecs [8];

    initial begin
        wcyc[0] = 1;
        wcyc[1] = 3;
        cyc = 0;
        total_cnt = 0;
        pass_cnt = 0;
        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b0; we[u] = 1'b0; addr_in[u] = 32'h0; wdata[u] = 32'h0;
            rd_cnt[u] = 0; wr_cnt[u] = 0; bad[u] = 1'b0; had_stb[u] = 1'b0;
            addr_hold[u] = 32'h0;
        end

        vecs[0] = '{1'b1, 32'h0000_008E, 32'h0000_0009, 1'b0, 32'h0000_0009};
        vecs[1] = '{1'b0, 32'h0000_008E, 32'h0,         1'b0, 32'h0000_0009};
        vecs[2] = '{1'b0, 32'h0000_0047, 32'h0,         1'b0, 32'h0000_0094};
        vecs[3] = '{1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'h0000_0094};
        vecs[4] = '{1'b1, 32'h0000_01FF, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 32'h0000_008E, 32'h0,         1'b0, 32'h0000_0009};
        vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 32'h0000_0009};
        vecs[7] = '{1'b0, 32'h0000_01FF, 32'h0,         1'b0, 32'hDEAD_BEEF};

        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",    {31'd0, ready[0]},     32'd1);
        chk("reset_done",     {31'd0, done[0]},      32'd0);
        chk("reset_err",      {31'd0, err[0]},       32'd0);
        chk("reset_ram_read", {31'd0, ram_read[0]},  32'd0);
        chk("reset_ram_write",{31'd0, ram_write[0]}, 32'd0);
        chk("reset_rdata",    rdata[0],              32'd0);
        chk("reset_ram_addr", ram_addr[0],           32'd0);
        chk("reset_rdata3",   rdata[1],              32'd0);
        clr = 1'b0;

        fork
            forever begin
                @(negedge clk);
                mon_unit(0);
                mon_unit(1);
            end
        join_none

        for (int i = 0; i < 8; i++) begin
            start_acc(0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_err, vecs[i].exp_rdata);
            drain(0);
        end

        // Busy: a req during ACCESS is dropped, not queued.
        start_acc(0, 1'b0, 32'h47, 32'h0, 1'b0, 32'h94);
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr_in[0] = 32'h10; wdata[0] = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0; we[0] = 1'b0; addr_in[0] = 32'h0; wdata[0] = 32'h0;
        drain(0);
        repeat (5) @(negedge clk);
        chk("busy_rdata", rdata[0], 32'h94);
        chk("busy_ready", {31'd0, ready[0]}, 32'd1);

        // Abort: reset during the write strobe.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr_in[0] = 32'h20; wdata[0] = 32'hAB;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0; we[0] = 1'b0; addr_in[0] = 32'h0; wdata[0] = 32'h0;
        for (int n = 0; n < 10 && !ram_write[0]; n++) @(negedge clk);
        chk("abort_strobe_seen", {31'd0, ram_write[0]}, 32'd1);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("abort_done",      {31'd0, done[0]},      32'd0);
        chk("abort_ram_write", {31'd0, ram_write[0]}, 32'd0);
        chk("abort_ram_read",  {31'd0, ram_read[0]},  32'd0);
        chk("abort_ready",     {31'd0, ready[0]},     32'd1);
        chk("abort_rdata",     rdata[0],              32'd0);
        repeat (6) @(negedge clk);

        // WAIT_CYCLES=3 instance.
        start_acc(1, 1'b0, 32'h47, 32'h0, 1'b0, 32'h94);
        drain(1);
        start_acc(1, 1'b1, 32'h8E, 32'h1234_5678, 1'b0, 32'h1234_5678);
        drain(1);
        start_acc(1, 1'b0, 32'h47, 32'h0, 1'b0, 32'h94);
        drain(1);
        start_acc(1, 1'b0, 32'h8E, 32'h0, 1'b0, 32'h1234_5678);
        drain(1);
        start_acc(1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h1234_5678);
        drain(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
